encoder_stream: RTL and testbench

//   Inverse of decoder_param. Accepts a multi-hot vector and emits the index of every set bit as a

---
 rtl/encoder_stream.sv | 110 +++++++++++
 tb/tb_encoder_stream.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/encoder_stream.sv
// encoder_stream: multi-hot vector to stream of binary indices.
//
// Takes one multi-hot vector and emits the index of every set bit as a binary digit,
// lowest index first, one per valid/ready beat. An all-zero vector produces a single beat
// with digit=0, digit_none=1 and digit_last=1. Only one vector is held at a time.
//
// Parameters
//   OUT           digit width in bits; the vector is 2**OUT bits wide (legal 1..6)
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous reset, active low
//   vector        multi-hot input vector, sampled only on the accept edge
//   vector_valid  input vector is valid
//   vector_ready  block can accept a vector (IDLE)
//   digit         index of the current lowest set bit (0 for an all-zero vector)
//   digit_valid   digit/digit_last/digit_none are valid
//   digit_ready   consumer accepts the current beat
//   digit_last    final beat for the current vector
//   digit_none    the accepted vector was all-zero
module encoder_stream #(
  parameter int unsigned OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<OUT)-1:0]   vector,
  input  logic                  vector_valid,
  output logic                  vector_ready,
  output logic [OUT-1:0]        digit,
  output logic                  digit_valid,
  input  logic                  digit_ready,
  output logic                  digit_last,
  output logic                  digit_none
);

  localparam int unsigned W = 1 << OUT;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e         state_q;
  logic [W-1:0]   pending_q;
  logic           zero_flag_q;
  logic           vector_ready_q;
  logic           digit_valid_q;

  logic [W-1:0]   pending_dec;
  logic [OUT-1:0] lowest;
  logic           last_beat;

  // pending & (pending - 1) drops the lowest set bit; a zero result means at most one bit is
  // left, which is exactly the popcount<=1 condition for the final beat.
  assign pending_dec = pending_q - {{(W-1){1'b0}}, 1'b1};
  assign last_beat   = ((pending_q & pending_dec) == '0);

  // Priority encoder: scan downwards so the lowest set bit wins.
  always_comb begin
    lowest = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest = OUT'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      zero_flag_q    <= 1'b0;
      vector_ready_q <= 1'b1;
      digit_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (vector_valid) begin
            pending_q      <= vector;
            zero_flag_q    <= (vector == '0);
            state_q        <= StScan;
            vector_ready_q <= 1'b0;
            digit_valid_q  <= 1'b1;
          end
        end
        StScan: begin
          if (digit_ready) begin
            pending_q <= pending_q & pending_dec;
            if (last_beat) begin
              state_q        <= StIdle;
              zero_flag_q    <= 1'b0;
              vector_ready_q <= 1'b1;
              digit_valid_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q        <= StIdle;
          pending_q      <= '0;
          zero_flag_q    <= 1'b0;
          vector_ready_q <= 1'b1;
          digit_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vector_ready = vector_ready_q;
  assign digit_valid  = digit_valid_q;

  // Beat fields come from registers only and are forced to 0 outside SCAN.
  assign digit      = digit_valid_q ? lowest : '0;
  assign digit_last = digit_valid_q & last_beat;
  assign digit_none = digit_valid_q & zero_flag_q;

endmodule

// File: tb/tb_encoder_stream.sv
module tb_encoder_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] vector;
  logic        vector_valid;
  logic        vector_ready;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        digit_ready;
  logic        digit_last;
  logic        digit_none;

  int n_cmp = 0;
  int n_err = 0;

  encoder_stream #(.OUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .digit_ready  (digit_ready),
    .digit_last   (digit_last),
    .digit_none   (digit_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per input vector: expected digits packed one nibble per beat, beat 0 lowest.
  typedef struct {
    logic [15:0] vec;
    int          nbeats;
    logic [63:0] digs;
    logic        none;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the block idle; returns at a negedge after the last beat.
  task automatic run_vector(input vec_t t);
    @(negedge clk);
    check("vector_ready before accept", 64'(vector_ready), 64'd1);
    vector       = t.vec;
    vector_valid = 1'b1;
    @(negedge clk);
    vector_valid = 1'b0;
    vector       = ~t.vec;  // must be ignored after the accept edge
    for (int b = 0; b < t.nbeats; b++) begin
      check("digit_valid", 64'(digit_valid), 64'd1);
      check("digit", 64'(digit), 64'(t.digs[b*4 +: 4]));
      check("digit_last", 64'(digit_last), (b == t.nbeats - 1) ? 64'd1 : 64'd0);
      check("digit_none", 64'(digit_none), 64'(t.none));
      check("vector_ready in scan", 64'(vector_ready), 64'd0);
      if (t.nbeats == 1 && !t.none)
        check("decode round trip", 64'(16'd1 << digit), 64'(t.vec));
      @(negedge clk);
    end
    check("vector_ready after last", 64'(vector_ready), 64'd1);
    check("digit_valid after last", 64'(digit_valid), 64'd0);
  endtask

  initial begin
    vec_t t;
    vector       = 16'h0;
    vector_valid = 1'b0;
    digit_ready  = 1'b1;
    rst_n        = 1'b0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset vector_ready", 64'(vector_ready), 64'd1);
      check("reset digit_valid", 64'(digit_valid), 64'd0);
      check("reset digit", 64'(digit), 64'd0);
      check("reset digit_last", 64'(digit_last), 64'd0);
      check("reset digit_none", 64'(digit_none), 64'd0);
    end
    rst_n = 1'b1;

    // One-hot sweep: single beat with digit = i
    for (int i = 0; i < 16; i++) begin
      t.vec = 16'd1 << i; t.nbeats = 1; t.digs = 64'(i); t.none = 1'b0;
      tbl.push_back(t);
    end
    t.vec = 16'h8421; t.nbeats = 4;  t.digs = 64'h0000_0000_0000_FA50;   t.none = 1'b0;
    tbl.push_back(t);
    t.vec = 16'h0000; t.nbeats = 1;  t.digs = 64'h0;                     t.none = 1'b1;
    tbl.push_back(t);
    t.vec = 16'hFFFF; t.nbeats = 16; t.digs = 64'hFEDC_BA98_7654_3210;   t.none = 1'b0;
    tbl.push_back(t);
    t.vec = 16'hA006; t.nbeats = 4;  t.digs = 64'h0000_0000_0000_FD21;   t.none = 1'b0;
    tbl.push_back(t);

    foreach (tbl[k]) run_vector(tbl[k]);

    // Backpressure: 0x0003 with digit_ready low for 3 cycles
    digit_ready = 1'b0;
    @(negedge clk);
    vector = 16'h0003; vector_valid = 1'b1;
    @(negedge clk);
    vector_valid = 1'b0; vector = 16'h0;
    for (int i = 0; i < 3; i++) begin
      check("bp digit_valid", 64'(digit_valid), 64'd1);
      check("bp digit held", 64'(digit), 64'd0);
      check("bp last held", 64'(digit_last), 64'd0);
      @(negedge clk);
    end
    digit_ready = 1'b1;
    check("bp beat0 digit", 64'(digit), 64'd0);
    check("bp beat0 last", 64'(digit_last), 64'd0);
    @(negedge clk);
    check("bp beat1 digit", 64'(digit), 64'd1);
    check("bp beat1 last", 64'(digit_last), 64'd1);
    @(negedge clk);
    check("bp done ready", 64'(vector_ready), 64'd1);

    // Reset mid-scan on 0xFFFF after 3 beats
    vector = 16'hFFFF; vector_valid = 1'b1;
    @(negedge clk);
    vector_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pre-reset digit", 64'(digit), 64'(i));
      @(negedge clk);
    end
    check("pre-reset valid", 64'(digit_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset digit_valid", 64'(digit_valid), 64'd0);
    check("async reset vector_ready", 64'(vector_ready), 64'd1);
    check("async reset digit", 64'(digit), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t.vec = 16'h0010; t.nbeats = 1; t.digs = 64'd4; t.none = 1'b0;
    run_vector(t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
